// File: rtl/frankie_fetch_unit.sv
// Frankie instruction-fetch front end: req/ack fetch FSM feeding a PC-tagged first-word-fall-through prefetch FIFO.
// Optional macro FETCH_STATS_EN adds saturating fetch/flush counters (o_stat_fetches, o_stat_flushes).
module frankie_fetch_unit #(
  parameter int                INST_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_mem_req,
  output logic [ADDR_W-1:0]       o_mem_addr,
  input  logic                    i_mem_ack,
  input  logic [INST_W-1:0]       i_mem_rdata,
  output logic                    o_inst_valid,
  output logic [INST_W-1:0]       o_inst_data,
  output logic [ADDR_W-1:0]       o_inst_pc,
  input  logic                    i_inst_ready,
  input  logic                    i_redirect,
  input  logic [ADDR_W-1:0]       i_redirect_pc,
`ifdef FETCH_STATS_EN
  output logic [15:0]             o_stat_fetches,
  output logic [15:0]             o_stat_flushes,
`endif
  output logic [$clog2(DEPTH):0]  o_fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic                r_mem_req;
  logic [INST_W-1:0]   r_data_mem [DEPTH];
  logic [ADDR_W-1:0]   r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [CNT_W-1:0]    r_count, w_count_next, w_count_after_pop;
  logic                r_inst_valid, w_inst_valid_next;
  logic [INST_W-1:0]   r_inst_data, w_inst_data_next;
  logic [ADDR_W-1:0]   r_inst_pc, w_inst_pc_next;
  logic                w_push, w_pop;

  // Redirect discards any same-cycle push or pop.
  assign w_push            = (r_state == S_REQ) && i_mem_ack && !i_redirect;
  assign w_pop             = r_inst_valid && i_inst_ready && !i_redirect;
  assign w_pc_inc          = r_fetch_pc + PC_STEP;
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign w_rd_ptr_next     = r_rd_ptr + PTR_W'(w_pop);

  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_inst_valid = r_inst_valid;
  assign o_inst_data  = r_inst_data;
  assign o_inst_pc    = r_inst_pc;
  assign o_fifo_count = r_count;

  // Occupancy after this edge.
  always_comb begin
    w_count_next = {CNT_W{1'b0}};
    if (i_redirect) begin
      w_count_next = {CNT_W{1'b0}};
    end else begin
      w_count_next = w_count_after_pop + CNT_W'(w_push);
    end
  end

  // Next FIFO head; an ack into an effectively empty FIFO bypasses storage.
  always_comb begin
    w_inst_valid_next = 1'b0;
    w_inst_data_next  = {INST_W{1'b0}};
    w_inst_pc_next    = {ADDR_W{1'b0}};
    if (i_redirect || (w_count_next == {CNT_W{1'b0}})) begin
      w_inst_valid_next = 1'b0;
    end else if (w_count_after_pop == {CNT_W{1'b0}}) begin
      w_inst_valid_next = 1'b1;
      w_inst_data_next  = i_mem_rdata;
      w_inst_pc_next    = r_fetch_pc;
    end else begin
      w_inst_valid_next = 1'b1;
      w_inst_data_next  = r_data_mem[w_rd_ptr_next];
      w_inst_pc_next    = r_pc_mem[w_rd_ptr_next];
    end
  end

  // Fetch FSM next state, next fetch PC and next request address.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_mem_addr_next = r_mem_addr;
    if (i_redirect) begin
      w_fetch_pc_next = i_redirect_pc;
      if (r_mem_req && !i_mem_ack) begin
        w_state_next = S_DROP;
      end else begin
        w_state_next    = S_REQ;
        w_mem_addr_next = i_redirect_pc;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < FULL) begin
            w_state_next    = S_REQ;
            w_mem_addr_next = r_fetch_pc;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            w_fetch_pc_next = w_pc_inc;
            w_mem_addr_next = w_pc_inc;
            if (w_count_next < FULL) begin
              w_state_next = S_REQ;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_state_next = S_REQ;
          end
        end
        S_DROP: begin
          if (i_mem_ack) begin
            w_state_next    = S_REQ;
            w_mem_addr_next = r_fetch_pc;
          end else begin
            w_state_next = S_DROP;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Control, pointer and head registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_mem_addr   <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_wr_ptr     <= {PTR_W{1'b0}};
      r_rd_ptr     <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_inst_valid <= 1'b0;
      r_inst_data  <= {INST_W{1'b0}};
      r_inst_pc    <= {ADDR_W{1'b0}};
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_req    <= (w_state_next != S_IDLE);
      r_count      <= w_count_next;
      r_inst_valid <= w_inst_valid_next;
      r_inst_data  <= w_inst_data_next;
      r_inst_pc    <= w_inst_pc_next;
      if (i_redirect) begin
        r_wr_ptr <= {PTR_W{1'b0}};
        r_rd_ptr <= {PTR_W{1'b0}};
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
        r_rd_ptr <= w_rd_ptr_next;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data_mem[i] <= {INST_W{1'b0}};
        r_pc_mem[i]   <= {ADDR_W{1'b0}};
      end
    end else if (w_push) begin
      r_data_mem[r_wr_ptr] <= i_mem_rdata;
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] r_stat_fetches, r_stat_flushes;

  assign o_stat_fetches = r_stat_fetches;
  assign o_stat_flushes = r_stat_flushes;

  // Saturating counters of accepted words and redirects.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_fetches <= 16'h0000;
      r_stat_flushes <= 16'h0000;
    end else begin
      if (w_push && (r_stat_fetches != 16'hFFFF)) begin
        r_stat_fetches <= r_stat_fetches + 16'h0001;
      end
      if (i_redirect && (r_stat_flushes != 16'hFFFF)) begin
        r_stat_flushes <= r_stat_flushes + 16'h0001;
      end
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule

// File: tb/tb_frankie_fetch_unit.sv
// Self-checking bench for frankie_fetch_unit: queue scoreboard of expected {pc, data}, vector table plus directed corners.
module tb_frankie_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack, inst_valid, inst_ready, redirect;
  logic [15:0] mem_addr, mem_rdata, inst_data, inst_pc, redirect_pc;
  logic [2:0]  fifo_count;
  logic        w_req, w_ack, w_valid, w_rdy;
  logic [15:0] w_addr, w_rdata, w_data, w_pc;
  logic [2:0]  w_count;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetches, stat_flushes, w_sf, w_sl;
`endif

  always #5 clk = ~clk;

  frankie_fetch_unit #(.INST_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(16'h0001)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .o_inst_valid(inst_valid), .o_inst_data(inst_data), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
`ifdef FETCH_STATS_EN
    .o_stat_fetches(stat_fetches), .o_stat_flushes(stat_flushes),
`endif
    .o_fifo_count(fifo_count));

  frankie_fetch_unit #(.INST_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE), .PC_STEP(16'h0001)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(w_req), .o_mem_addr(w_addr), .i_mem_ack(w_ack),
    .i_mem_rdata(w_rdata), .o_inst_valid(w_valid), .o_inst_data(w_data), .o_inst_pc(w_pc),
    .i_inst_ready(w_rdy), .i_redirect(1'b0), .i_redirect_pc(16'h0000),
`ifdef FETCH_STATS_EN
    .o_stat_fetches(w_sf), .o_stat_flushes(w_sl),
`endif
    .o_fifo_count(w_count));

  typedef struct packed { logic [15:0] pc; logic [15:0] data; } ent_t;
  typedef struct {
    logic [15:0] rpc; int n; logic [7:0] ack_pat; logic [7:0] rdy_pat;
    logic [15:0] exp_first_pc; logic [2:0] max_cnt; logic exp_stream;
  } vec_t;

  ent_t        q[$];
  vec_t        vecs[4];
  int          checks = 0, errors = 0;
  logic [15:0] exp_addr, drop_addr, prev_addr;
  logic        drop_pending, prev_pending, seen, found;
  int          n_fetch, n_flush;
  logic [15:0] wrap_tab[3];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(mem_req),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr),   32'h0000);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_data"},  32'(inst_data),  32'd0);
    chk({tag, "_pc"},    32'(inst_pc),    32'd0);
  endtask

  // One clock: drive inputs, update scoreboard, sample #1 after the edge and compare.
  task automatic cycle(input logic redir, input logic [15:0] rpc, input logic ack_en, input logic rdy);
    ent_t e;
    logic acked, popped;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ack     = ack_en & mem_req;
    mem_rdata   = mem_word(mem_addr);
    inst_ready  = rdy;
    acked  = mem_ack;
    popped = inst_valid & rdy;
    if (acked) begin
      if (drop_pending) begin
        chk("drop_addr", 32'(mem_addr), 32'(drop_addr));
        drop_pending = 1'b0;
      end else begin
        chk("ack_addr", 32'(mem_addr), 32'(exp_addr));
        if (!redir) begin
          e.pc = exp_addr;
          e.data = mem_word(exp_addr);
          q.push_back(e);
          exp_addr = exp_addr + 16'h0001;
          if (n_fetch < 32'hFFFF) n_fetch++;
        end
      end
    end
    if (redir) begin
      q.delete();
      exp_addr = rpc;
      if (n_flush < 32'hFFFF) n_flush++;
      if (mem_req && !acked && !drop_pending) begin
        drop_pending = 1'b1;
        drop_addr = mem_addr;
      end
    end else if (popped) begin
      void'(q.pop_front());
    end
    prev_pending = mem_req & ~acked;
    prev_addr    = mem_addr;
    @(posedge clk);
    #1;
    if (prev_pending) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_held", 32'(mem_addr), 32'(prev_addr));
    end
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_pc", 32'(inst_pc), 32'(q[0].pc));
      chk("head_data", 32'(inst_data), 32'(q[0].data));
    end
    if (q.size() == DEPTH) chk("full_no_req", 32'(mem_req), 32'd0);
  endtask

`ifdef FETCH_STATS_EN
  task automatic chk_stats(input string tag);
    chk({tag, "_fetches"}, 32'(stat_fetches), 32'(n_fetch));
    chk({tag, "_flushes"}, 32'(stat_flushes), 32'(n_flush));
  endtask
`endif

  initial begin
    vecs[0] = '{16'h0100, 20, 8'hFF, 8'hFF, 16'h0100, 3'd1, 1'b1};
    vecs[1] = '{16'h0200, 24, 8'h55, 8'hFF, 16'h0200, 3'd1, 1'b0};
    vecs[2] = '{16'h1234, 24, 8'hFF, 8'h11, 16'h1234, 3'd4, 1'b0};
    vecs[3] = '{16'hABCD, 24, 8'h93, 8'h6C, 16'hABCD, 3'd4, 1'b0};
    wrap_tab[0] = 16'hFFFE; wrap_tab[1] = 16'hFFFF; wrap_tab[2] = 16'h0000;

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0; w_ack = 1'b0; w_rdata = 16'h0; w_rdy = 1'b0;
    exp_addr = 16'h0000; drop_pending = 1'b0; prev_pending = 1'b0; drop_addr = 16'h0;
    n_fetch = 0; n_flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Fill to DEPTH with no consumer, then one pop re-opens fetch at address 4.
    repeat (8) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_req", 32'(mem_req), 32'd0);
    cycle(1'b0, 16'h0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (mem_req) begin
        found = 1'b1;
        chk("refetch_addr", 32'(mem_addr), 32'h0004);
      end else begin
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
      end
    end
    chk("refetch_seen", 32'(found), 32'd1);

    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, vecs[k].rpc, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < vecs[k].n; i++) begin
        cycle(1'b0, 16'h0, vecs[k].ack_pat[i % 8], vecs[k].rdy_pat[i % 8]);
        chk("max_cnt", 32'(fifo_count <= vecs[k].max_cnt), 32'd1);
        if (seen && vecs[k].exp_stream) chk("stream_gap", 32'(inst_valid), 32'd1);
        if (!seen && inst_valid) begin
          seen = 1'b1;
          chk("first_pc", 32'(inst_pc), 32'(vecs[k].exp_first_pc));
        end
      end
      chk("first_pc_seen", 32'(seen), 32'd1);
    end

    // Redirect while the request to 0x0003 is outstanding; its word must vanish.
    cycle(1'b1, 16'h0003, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (mem_req && (mem_addr == 16'h0003) && !drop_pending) found = 1'b1;
      else cycle(1'b0, 16'h0, 1'b1, 1'b1);
    end
    chk("s3_req3", 32'(found), 32'd1);
    cycle(1'b1, 16'h0040, 1'b0, 1'b1);
    chk("s3_hold_req", 32'(mem_req), 32'd1);
    chk("s3_hold_addr", 32'(mem_addr), 32'h0003);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1, 1'b1);
    chk("s3_next_req", 32'(mem_req), 32'd1);
    chk("s3_next_addr", 32'(mem_addr), 32'h0040);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      if (inst_valid) begin
        chk("s3_no_stale", 32'(inst_pc != 16'h0003), 32'd1);
        if (!seen) chk("s3_first_pc", 32'(inst_pc), 32'h0040);
        seen = 1'b1;
      end
    end
`ifdef FETCH_STATS_EN
    chk_stats("s3");
`endif

    // Redirect coincident with pop and ack at occupancy 2.
    cycle(1'b1, 16'h0500, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() != 2; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("s4_count2", 32'(fifo_count), 32'd2);
    chk("s4_req", 32'(mem_req), 32'd1);
    cycle(1'b1, 16'h0600, 1'b1, 1'b1);
    chk("s4_count0", 32'(fifo_count), 32'd0);
    chk("s4_valid0", 32'(inst_valid), 32'd0);
    repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b1);

    // Address wrap on the second instance.
    redirect = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    begin
      int nw, np;
      nw = 0; np = 0;
      for (int i = 0; i < 8; i++) begin
        w_ack = w_req; w_rdata = mem_word(w_addr); w_rdy = 1'b1;
        if (w_req) begin
          if (nw < 3) chk("wrap_addr", 32'(w_addr), 32'(wrap_tab[nw]));
          nw++;
        end
        @(posedge clk);
        #1;
        if (w_valid) begin
          if (np < 3) begin
            chk("wrap_pc", 32'(w_pc), 32'(wrap_tab[np]));
            chk("wrap_data", 32'(w_data), 32'(mem_word(wrap_tab[np])));
          end
          np++;
        end
      end
      chk("wrap_pops", 32'(np >= 3), 32'd1);
      w_ack = 1'b0; w_rdy = 1'b0;
    end

`ifdef FETCH_STATS_EN
    chk_stats("pre_sat");
    for (int i = 0; i < 66000; i++) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    chk("sat_fetches", 32'(stat_fetches), 32'h0000FFFF);
    chk_stats("sat");
`endif

    // Reset asserted mid-transaction with a late ack.
    mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk);
    #1;
    chk_reset("late_ack");
    mem_ack = 1'b0;
    rst_n = 1'b1;
    q.delete(); exp_addr = 16'h0000; drop_pending = 1'b0; prev_pending = 1'b0;
    n_fetch = 0; n_flush = 0;
    repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_count", 32'(fifo_count), 32'd4);
`ifdef FETCH_STATS_EN
    chk_stats("post_rst");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
